// File: rtl/mux_nx1_seq_if.sv
// Channel bank, selection control and registered result of mux_nx1_seq.
// The controller owns the master side; the mux owns the slave side.
interface mux_nx1_seq_if #(
  parameter int N    = 8,
  parameter int W    = 1,
  parameter int SELW = $clog2(N)
);
  logic [N*W-1:0]  in;
  logic [SELW-1:0] sel_in;
  logic            sel_load;
  logic            mode;
  logic            hold;
  logic [W-1:0]    out;
  logic [SELW-1:0] sel_out;
  logic            out_valid;
  logic            wrap;
  logic            err;

  modport master (
    output in, sel_in, sel_load, mode, hold,
    input  out, sel_out, out_valid, wrap, err
  );

  modport slave (
    input  in, sel_in, sel_load, mode, hold,
    output out, sel_out, out_valid, wrap, err
  );
endinterface

// File: rtl/mux_nx1_seq.sv
// Registered N-to-1 mux with selection register and timed scan sequencer.
// Define MUX_SCAN_EN to build the scan sequencer; otherwise manual only.
module mux_nx1_seq #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int SELW  = $clog2(N),
  parameter int DWELL = 4
) (
  input logic        clk,
  input logic        rst,
  mux_nx1_seq_if.slave bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SELW:0]   NLIM = (SELW+1)'(N);
  localparam logic [SELW-1:0] SMAX = SELW'(N - 1);

  logic [SELW-1:0] sel_q, sel_d;
  logic [W-1:0]    out_q, out_d;
  logic            vld_q;
  logic            wrap_q, wrap_d;
  logic            err_q, err_d;

  logic in_rng;
  logic ld_ok, ld_bad;
  logic frz, stp, man;

  assign in_rng = {1'b0, bus.sel_in} < NLIM;
  assign ld_ok  = bus.sel_load & in_rng;
  assign ld_bad = bus.sel_load & ~in_rng;

`ifdef MUX_SCAN_EN
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign frz = ~bus.sel_load & bus.mode & bus.hold;
  assign stp = ~bus.sel_load & bus.mode & ~bus.hold;
  assign man = ~bus.sel_load & ~bus.mode;
`else
  logic unused_scan;

  assign unused_scan = bus.mode ^ bus.hold;
  assign frz = 1'b0;
  assign stp = 1'b0;
  assign man = ~bus.sel_load;
`endif

  // The output always reflects the selection held before this edge.
  assign out_d = bus.in[int'(sel_q)*W +: W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef MUX_SCAN_EN
      cnt_q  <= '0;
`endif
    end else begin
      sel_q  <= sel_d;
      out_q  <= out_d;
      vld_q  <= 1'b1;
      wrap_q <= wrap_d;
      err_q  <= err_d;
`ifdef MUX_SCAN_EN
      cnt_q  <= cnt_d;
`endif
    end
  end

  always_comb begin
    sel_d  = sel_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
`ifdef MUX_SCAN_EN
    cnt_d  = cnt_q;
`endif
    unique case (1'b1)
      ld_ok: begin
        sel_d = bus.sel_in;
`ifdef MUX_SCAN_EN
        cnt_d = '0;
`endif
      end
      ld_bad: err_d = 1'b1;
      frz: ;
      stp: begin
`ifdef MUX_SCAN_EN
        if (cnt_q != LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (sel_q == SMAX) begin
            sel_d  = '0;
            wrap_d = 1'b1;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
`endif
      end
      man: begin
`ifdef MUX_SCAN_EN
        cnt_d = '0;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.out       = out_q;
    bus.sel_out   = sel_q;
    bus.out_valid = vld_q;
    bus.wrap      = wrap_q;
    bus.err       = err_q;
  end

endmodule
